cdb_arbiter: RTL and testbench

//  Complete-stage arbiter directly downstream of the functional units (alu, mult, load, branch).

---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_arbiter_grant.sv | 46 ++++
 rtl/cdb_arbiter.sv | 77 +++++++
 tb/tb_cdb_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the complete-stage / CDB arbiter.
//   FU_PACKET : registered functional-unit output carried on the CDB
//   FU_IDX    : functional-unit index at the default NUM_FU (rr_ptr width)
package cdb_arbiter_pkg;

  localparam int NUM_FU_DEF = 4;
  localparam int CDB_SZ_DEF = 2;

  typedef logic [$clog2(NUM_FU_DEF)-1:0] FU_IDX;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] decoded_vals;
    logic        take_conditional;
  } FU_PACKET;

endpackage

// File: rtl/cdb_arbiter_grant.sv
// rr_grant_n: combinational rotating-priority picker.
// Scans req starting at ptr (wrapping mod NUM_FU) and grants the first n
// set bits, capped at CDB_SZ.
//   req      in  NUM_FU          request vector
//   ptr      in  IDX_W           highest-priority index
//   n        in  NW              max grants this cycle
//   grant    out NUM_FU          granted requesters
//   lane_sel out CDB_SZ x IDX_W  requester index feeding each lane
//   lane_vld out CDB_SZ          lane carries a grant (packed from lane 0)
module rr_grant_n #(
  parameter int NUM_FU = 4,
  parameter int CDB_SZ = 2,
  parameter int IDX_W  = $clog2(NUM_FU),
  parameter int NW     = $clog2(CDB_SZ+1)
) (
  input  logic [NUM_FU-1:0]             req,
  input  logic [IDX_W-1:0]              ptr,
  input  logic [NW-1:0]                 n,
  output logic [NUM_FU-1:0]             grant,
  output logic [CDB_SZ-1:0][IDX_W-1:0]  lane_sel,
  output logic [CDB_SZ-1:0]             lane_vld
);

  // Walking positions in rotated order is the same as rotate/pick/unrotate,
  // and the running count gives each grant its lane directly.
  always_comb begin
    int cnt;
    int idx;
    grant    = '0;
    lane_sel = '0;
    lane_vld = '0;
    cnt      = 0;
    idx      = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(ptr) + j;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (req[idx] && cnt < int'(n) && cnt < CDB_SZ) begin
        grant[idx]    = 1'b1;
        lane_sel[cnt] = IDX_W'(idx);
        lane_vld[cnt] = 1'b1;
        cnt           = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: registers up to CDB_SZ ready FU packets per cycle onto the
// CDB lanes under rotating priority; losers are stalled and hold.
//   clock, reset (async, active-high)
//   fu_packs  in  NUM_FU x FU_PACKET  FU output registers
//   fu_ready  in  NUM_FU              per-FU data_ready
//   squash    in  1                   flush: no broadcast, no stall, ptr holds
//   fu_stall  out NUM_FU              combinational per-FU stall
//   cdb_packs out CDB_SZ x FU_PACKET  registered broadcast packets
//   cdb_valid out CDB_SZ              registered lane valids
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int CDB_SZ = CDB_SZ_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  FU_PACKET [NUM_FU-1:0]     fu_packs,
  input  logic [NUM_FU-1:0]         fu_ready,
  input  logic                      squash,
  output logic [NUM_FU-1:0]         fu_stall,
  output FU_PACKET [CDB_SZ-1:0]     cdb_packs,
  output logic [CDB_SZ-1:0]         cdb_valid
);

  localparam int IDX_W = $clog2(NUM_FU);
  localparam int NW    = $clog2(CDB_SZ+1);

  logic [IDX_W-1:0]             rr_ptr;
  logic [IDX_W-1:0]             last_idx;
  logic [IDX_W-1:0]             nxt_ptr;
  logic [NUM_FU-1:0]            grant;
  logic [CDB_SZ-1:0][IDX_W-1:0] lane_sel;
  logic [CDB_SZ-1:0]            lane_vld;
  FU_PACKET [CDB_SZ-1:0]        nxt_packs;

  rr_grant_n #(.NUM_FU(NUM_FU), .CDB_SZ(CDB_SZ), .IDX_W(IDX_W), .NW(NW)) u_grant (
    .req      (fu_ready),
    .ptr      (rr_ptr),
    .n        (NW'(CDB_SZ)),
    .grant    (grant),
    .lane_sel (lane_sel),
    .lane_vld (lane_vld)
  );

  assign fu_stall = fu_ready & ~grant & {NUM_FU{~squash}};

  // Lane mux plus next pointer: one past the highest-numbered lane in use,
  // which is the last FU granted in priority order.
  always_comb begin
    nxt_packs = '0;
    last_idx  = '0;
    for (int k = 0; k < CDB_SZ; k++) begin
      if (lane_vld[k]) begin
        nxt_packs[k] = fu_packs[lane_sel[k]];
        last_idx     = lane_sel[k];
      end
    end
    nxt_ptr = (last_idx == IDX_W'(NUM_FU-1)) ? '0 : last_idx + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid <= '0;
      cdb_packs <= '0;
      rr_ptr    <= '0;
    end else if (squash) begin
      cdb_valid <= '0;
      cdb_packs <= '0;
    end else begin
      cdb_valid <= lane_vld;
      cdb_packs <= nxt_packs;
      if (|grant) rr_ptr <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NF = 4;
  localparam int CS = 2;

  logic               clock = 1'b0;
  logic               reset;
  FU_PACKET [NF-1:0]  fu_packs;
  logic [NF-1:0]      fu_ready;
  logic               squash;
  logic [NF-1:0]      fu_stall;
  FU_PACKET [CS-1:0]  cdb_packs;
  logic [CS-1:0]      cdb_valid;

  int vec  = 0;
  int miss = 0;

  cdb_arbiter #(.NUM_FU(NF), .CDB_SZ(CS)) dut (
    .clock(clock), .reset(reset), .fu_packs(fu_packs), .fu_ready(fu_ready),
    .squash(squash), .fu_stall(fu_stall), .cdb_packs(cdb_packs), .cdb_valid(cdb_valid)
  );

  always #5 clock = ~clock;

  function automatic FU_PACKET mk(input logic [31:0] r);
    FU_PACKET p;
    p.alu_result       = r;
    p.decoded_vals     = {r[15:0], ~r[15:0]};
    p.take_conditional = r[1];
    return p;
  endfunction

  // Advance one edge and sample 1ns later; structural invariants every cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    vec++;
    if ($countones(cdb_valid) > CS) begin
      miss++; $display("FAIL lane_count: got %b", cdb_valid);
    end
    for (int k = 1; k < CS; k++) begin
      vec++;
      if (cdb_valid[k] && !cdb_valid[k-1]) begin
        miss++; $display("FAIL lane_hole: got %b", cdb_valid);
      end
    end
    vec++;
    if ((fu_stall & ~fu_ready) != '0) begin
      miss++; $display("FAIL stall_not_ready: stall %b ready %b", fu_stall, fu_ready);
    end
  endtask

  task automatic test_reset();
    fu_packs = {mk(32'h33), mk(32'h22), mk(32'h11), mk(32'h00)};
    fu_ready = 4'b1111;
    reset = 1'b0;
    #1;
    vec++; if (fu_stall !== 4'b1100) begin miss++; $display("FAIL rst_stall0: got %b want 1100", fu_stall); end
    tick();
    vec++; if (cdb_valid !== 2'b11 || cdb_packs[0] !== mk(32'h00) || cdb_packs[1] !== mk(32'h11)) begin
      miss++; $display("FAIL rst_first_grant: got %b %h %h want 11 FU0 FU1", cdb_valid,
                       cdb_packs[0].alu_result, cdb_packs[1].alu_result);
    end
    vec++; if (dut.rr_ptr !== 2'd2) begin miss++; $display("FAIL rst_ptr_adv: got %0d want 2", dut.rr_ptr); end
    // Mid-cycle async reset with traffic still present.
    #2 reset = 1'b1;
    #1;
    vec++; if (cdb_valid !== 2'b00 || cdb_packs !== '0) begin
      miss++; $display("FAIL rst_async: got %b want 00", cdb_valid);
    end
    vec++; if (dut.rr_ptr !== 2'd0) begin miss++; $display("FAIL rst_ptr: got %0d want 0", dut.rr_ptr); end
    #1 reset = 1'b0;
    #1;
    vec++; if (fu_stall !== 4'b1100) begin miss++; $display("FAIL rst_stall: got %b want 1100", fu_stall); end
    tick();
    vec++; if (cdb_valid !== 2'b11 || cdb_packs[0] !== mk(32'h00) || cdb_packs[1] !== mk(32'h11)) begin
      miss++; $display("FAIL rst_regrant: got %b %h %h want 11 FU0 FU1", cdb_valid,
                       cdb_packs[0].alu_result, cdb_packs[1].alu_result);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_stall [3];
    int         exp_l0 [3];
    int         exp_ptr [3];
    exp_stall = '{4'b1100, 4'b0011, 4'b1100};
    exp_l0    = '{0, 2, 0};
    exp_ptr   = '{2, 0, 2};
    reset = 1'b1; #1 reset = 1'b0;
    fu_packs = {mk(32'hF3), mk(32'hF2), mk(32'hF1), mk(32'hF0)};
    fu_ready = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      vec++; if (fu_stall !== exp_stall[c]) begin
        miss++; $display("FAIL fair_stall[%0d]: got %b want %b", c, fu_stall, exp_stall[c]);
      end
      tick();
      vec++; if (cdb_valid !== 2'b11 || cdb_packs[0] !== fu_packs[exp_l0[c]] ||
                 cdb_packs[1] !== fu_packs[exp_l0[c]+1]) begin
        miss++; $display("FAIL fair_lanes[%0d]: got %h %h want FU%0d FU%0d", c,
                         cdb_packs[0].alu_result, cdb_packs[1].alu_result, exp_l0[c], exp_l0[c]+1);
      end
      vec++; if (int'(dut.rr_ptr) != exp_ptr[c]) begin
        miss++; $display("FAIL fair_ptr[%0d]: got %0d want %0d", c, dut.rr_ptr, exp_ptr[c]);
      end
    end
  endtask

  task automatic test_single();
    fu_packs[2] = mk(32'h1234);
    fu_ready = 4'b0100;
    #1;
    vec++; if (fu_stall !== 4'b0000) begin miss++; $display("FAIL single_stall: got %b want 0000", fu_stall); end
    tick();
    vec++; if (cdb_valid !== 2'b01 || cdb_packs[0] !== mk(32'h1234) || cdb_packs[1] !== '0) begin
      miss++; $display("FAIL single_lane: got %b %h want 01 1234", cdb_valid, cdb_packs[0].alu_result);
    end
    vec++; if (dut.rr_ptr !== 2'd3) begin miss++; $display("FAIL single_ptr: got %0d want 3", dut.rr_ptr); end
  endtask

  task automatic test_wrap();
    fu_packs[0] = mk(32'hA);
    fu_packs[3] = mk(32'hD);
    fu_ready = 4'b1001;
    #1;
    vec++; if (fu_stall !== 4'b0000) begin miss++; $display("FAIL wrap_stall: got %b want 0000", fu_stall); end
    tick();
    vec++; if (cdb_valid !== 2'b11 || cdb_packs[0] !== mk(32'hD) || cdb_packs[1] !== mk(32'hA)) begin
      miss++; $display("FAIL wrap_lanes: got %b %h %h want 11 D A", cdb_valid,
                       cdb_packs[0].alu_result, cdb_packs[1].alu_result);
    end
    vec++; if (dut.rr_ptr !== 2'd1) begin miss++; $display("FAIL wrap_ptr: got %0d want 1", dut.rr_ptr); end
  endtask

  task automatic test_squash();
    fu_ready = 4'b0010;
    tick();
    vec++; if (dut.rr_ptr !== 2'd2) begin miss++; $display("FAIL sq_setup_ptr: got %0d want 2", dut.rr_ptr); end
    fu_ready = 4'b1111;
    squash = 1'b1;
    #1;
    vec++; if (fu_stall !== 4'b0000) begin miss++; $display("FAIL sq_stall: got %b want 0000", fu_stall); end
    tick();
    vec++; if (cdb_valid !== 2'b00 || cdb_packs !== '0) begin
      miss++; $display("FAIL sq_cdb: got %b want 00", cdb_valid);
    end
    vec++; if (dut.rr_ptr !== 2'd2) begin miss++; $display("FAIL sq_ptr: got %0d want 2", dut.rr_ptr); end
    squash = 1'b0;
  endtask

  task automatic test_hold();
    int seen = 0;
    fu_packs = {mk(32'h88), mk(32'h77), mk(32'h66), mk(32'h55)};
    fu_ready = 4'b1101;
    #1;
    vec++; if (fu_stall !== 4'b0001) begin miss++; $display("FAIL hold_stall: got %b want 0001", fu_stall); end
    tick();
    for (int k = 0; k < CS; k++) if (cdb_valid[k] && cdb_packs[k].alu_result == 32'h55) seen++;
    vec++; if (cdb_valid !== 2'b11 || cdb_packs[0] !== mk(32'h77) || cdb_packs[1] !== mk(32'h88)) begin
      miss++; $display("FAIL hold_c1: got %b %h %h want 11 77 88", cdb_valid,
                       cdb_packs[0].alu_result, cdb_packs[1].alu_result);
    end
    fu_ready = 4'b0001;
    #1;
    vec++; if (fu_stall !== 4'b0000) begin miss++; $display("FAIL hold_stall2: got %b want 0000", fu_stall); end
    tick();
    for (int k = 0; k < CS; k++) if (cdb_valid[k] && cdb_packs[k].alu_result == 32'h55) seen++;
    vec++; if (cdb_valid !== 2'b01 || cdb_packs[0] !== mk(32'h55)) begin
      miss++; $display("FAIL hold_c2: got %b %h want 01 55", cdb_valid, cdb_packs[0].alu_result);
    end
    fu_ready = 4'b0000;
    tick();
    for (int k = 0; k < CS; k++) if (cdb_valid[k] && cdb_packs[k].alu_result == 32'h55) seen++;
    vec++; if (cdb_valid !== 2'b00 || dut.rr_ptr !== 2'd1) begin
      miss++; $display("FAIL hold_idle: got %b ptr %0d want 00 ptr 1", cdb_valid, dut.rr_ptr);
    end
    vec++; if (seen != 1) begin miss++; $display("FAIL hold_once: got %0d want 1", seen); end
  endtask

  initial begin
    reset    = 1'b1;
    squash   = 1'b0;
    fu_ready = '0;
    fu_packs = '0;
    tick();
    vec++; if (cdb_valid !== 2'b00 || cdb_packs !== '0 || fu_stall !== 4'b0000) begin
      miss++; $display("FAIL reset_state: got %b stall %b want 00 0000", cdb_valid, fu_stall);
    end
    tick();
    test_reset();
    test_fairness();
    test_single();
    test_wrap();
    test_squash();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
